// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, pairs returned instructions with their PC and
// absorbs decode back-pressure with a one-entry hold buffer. FETCH_TRAP_EN enables trap redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef FETCH_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_pc,
  input  logic [31:0] i_insn,
  input  logic        i_imem_exception,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_insn,
  output logic [31:0] o_insn_pc,
  output logic        o_exception
`ifdef FETCH_TRAP_EN
  ,
  output logic [31:0] o_trap_pc
`endif
);

  localparam logic        ST_RUN  = 1'b0;
  localparam logic        ST_HOLD = 1'b1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        r_state;
  logic [31:0] r_fetch_pc;
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_exc;
  logic [31:0] r_h_insn;
  logic [31:0] r_h_pc;
  logic        r_h_exc;

  logic        w_hold;
  logic        w_valid;
  logic [31:0] w_insn;
  logic [31:0] w_insn_pc;
  logic        w_exc;
  logic        w_capture;
  logic        w_advance;
  logic [31:0] w_next_pc;

  assign w_hold    = (r_state == ST_HOLD);
  assign w_valid   = (w_hold | r_valid) & ~i_redirect_valid;
  assign w_insn    = w_hold ? r_h_insn : (r_exc ? NOP : i_insn);
  assign w_insn_pc = w_hold ? r_h_pc : r_pc;
  assign w_exc     = w_hold ? r_h_exc : r_exc;

  // Capture only from RUN; the redirect term is already folded into w_valid.
  assign w_capture = ~w_hold & w_valid & ~i_ready;
  assign w_advance = ~i_redirect_valid & (w_hold ? i_ready : ~w_capture);

`ifdef FETCH_TRAP_EN
  logic [31:0] r_trap_pc;

  assign w_next_pc = i_imem_exception ? TRAP_VECTOR : r_fetch_pc + 32'd4;
  assign o_trap_pc = r_trap_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trap_pc <= 32'h0000_0000;
    end else if (w_advance && i_imem_exception) begin
      r_trap_pc <= r_fetch_pc;
    end
  end
`else
  assign w_next_pc = r_fetch_pc + 32'd4;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_pc       <= 32'h0000_0000;
      r_exc      <= 1'b0;
      r_h_insn   <= 32'h0000_0000;
      r_h_pc     <= 32'h0000_0000;
      r_h_exc    <= 1'b0;
    end else if (i_redirect_valid) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= i_redirect_pc;
      r_valid    <= 1'b0;
    end else if (w_capture) begin
      // The fetch in flight is dropped; pc is held so it is re-issued on release.
      r_state  <= ST_HOLD;
      r_valid  <= 1'b0;
      r_h_insn <= w_insn;
      r_h_pc   <= w_insn_pc;
      r_h_exc  <= w_exc;
    end else if (w_advance) begin
      r_state    <= ST_RUN;
      r_valid    <= 1'b1;
      r_pc       <= r_fetch_pc;
      r_exc      <= i_imem_exception;
      r_fetch_pc <= w_next_pc;
    end
  end

  assign o_pc        = r_fetch_pc;
  assign o_valid     = w_valid;
  assign o_insn      = w_insn;
  assign o_insn_pc   = w_insn_pc;
  assign o_exception = w_exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected transfers follow program order from each
// reset/redirect target; a negedge monitor checks transfers, latencies, stalls and bubbles.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] TrapVec = 32'h0000_0100;
  localparam logic [31:0] Nop     = 32'h0000_0013;
`ifdef FETCH_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] o_pc;
  logic [31:0] mem_q;
  logic        imem_exc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        o_valid;
  logic        ready;
  logic [31:0] o_insn;
  logic [31:0] o_insn_pc;
  logic        o_exception;
  logic [31:0] trap_pc;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   since_rd = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_pc             (o_pc),
    .i_insn           (mem_q),
    .i_imem_exception (imem_exc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_valid          (o_valid),
    .i_ready          (ready),
    .o_insn           (o_insn),
    .o_insn_pc        (o_insn_pc),
`ifdef FETCH_TRAP_EN
    .o_trap_pc        (trap_pc),
`endif
    .o_exception      (o_exception)
  );

`ifndef FETCH_TRAP_EN
  assign trap_pc = 32'h0000_0000;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: mem_word = 32'h0000_0011;
      32'h4: mem_word = 32'h0000_0022;
      32'h8: mem_word = 32'h0000_0033;
      default: mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Registered instruction memory; misalignment flag is combinational on the address.
  always_ff @(posedge clk) mem_q <= mem_word(o_pc);
  assign imem_exc = (o_pc[1:0] != 2'b00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Program order from a start address, as decode should see it.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 48; i++) begin
      e.pc   = p;
      e.exc  = (p[1:0] != 2'b00);
      e.insn = e.exc ? Nop : mem_word(p);
      exp_q.push_back(e);
      p = (e.exc && TrapEn) ? TrapVec : p + 32'd4;
    end
  endtask

  task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    ready          = rdy;
    redirect_valid = rd;
    redirect_pc    = tgt;
    if (rd) begin
      push_stream(tgt);
      since_rd = 0;
    end else begin
      since_rd++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_stream(ResetPc);
    since_rd = 0;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    ready          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exp_q.delete();
    release_reset();
  endtask

  // Leaves the bench at posedge+1 of the cycle where addr is presented.
  task automatic wait_pc(input logic [31:0] addr);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      since_rd++;
      found = o_valid && (o_insn_pc == addr);
    end
    check("wait_pc_found", 32'(found), 32'd1);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    int          rs_age = 0;
    int          rd_age = 0;
    logic [31:0] rd_tgt = 0;
    bit          prev_stall = 0;
    bit          prev_xfer = 0;
    logic [31:0] prev_pc = 0;
    logic [31:0] prev_insn = 0;
    logic        prev_exc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_pc", o_pc, ResetPc);
        if (TrapEn) check("reset_trap_pc", trap_pc, 32'h0);
        rs_age     = 1;
        rd_age     = 0;
        prev_stall = 0;
        prev_xfer  = 0;
      end else begin
        if (rs_age == 1) begin
          check("release_idle", 32'(o_valid), 32'd0);
          rs_age = 2;
        end else if (rs_age == 2) begin
          check("first_valid", 32'(o_valid), 32'd1);
          check("first_pc", o_insn_pc, ResetPc);
          rs_age = 0;
        end
        if (redirect_valid) begin
          check("redirect_kill", 32'(o_valid), 32'd0);
          rd_age = 1;
          rd_tgt = redirect_pc;
        end else if (rd_age == 1) begin
          check("redirect_gap", 32'(o_valid), 32'd0);
          check("redirect_fetch_pc", o_pc, rd_tgt);
          rd_age = 2;
        end else if (rd_age == 2) begin
          check("redirect_valid_r2", 32'(o_valid), 32'd1);
          check("redirect_first_pc", o_insn_pc, rd_tgt);
          rd_age = 0;
        end
        if (!redirect_valid && prev_stall) begin
          check("stall_valid", 32'(o_valid), 32'd1);
          check("stall_pc", o_insn_pc, prev_pc);
          check("stall_insn", o_insn, prev_insn);
          check("stall_exc", 32'(o_exception), 32'(prev_exc));
        end
        if (!redirect_valid && prev_xfer) check("no_bubble", 32'(o_valid), 32'd1);
        if (o_valid && ready) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("xfer_pc", o_insn_pc, e.pc);
            check("xfer_insn", o_insn, e.insn);
            check("xfer_exc", 32'(o_exception), 32'(e.exc));
            if (TrapEn && e.exc) check("trap_pc", trap_pc, e.pc);
          end
        end
        prev_stall = o_valid && !ready;
        prev_xfer  = o_valid && ready;
        prev_pc    = o_insn_pc;
        prev_insn  = o_insn;
        prev_exc   = o_exception;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] tgt;
    bit          rd;
    // Basic run from reset.
    apply_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Three-cycle stall on 0x22@4.
    apply_reset();
    wait_pc(32'h4);
    ready = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Redirect coincident with release of a stall on 4.
    apply_reset();
    wait_pc(32'h4);
    ready = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Misaligned target, then PC wrap.
    step(1'b1, 1'b1, 32'h42);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Asynchronous reset in the middle of a stall.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(o_valid), 32'd0);
    check("async_reset_pc", o_pc, ResetPc);
    ready = 1'b1;
    exp_q.delete();
    release_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      r  = $urandom;
      rd = (since_rd >= 40) || ($urandom_range(99) < 5);
      case ($urandom_range(3))
        0: tgt = r & 32'hFFFF_FFFC;
        1: tgt = (r & 32'hFFFF_FFFC) | 32'h2;
        2: tgt = 32'hFFFF_FFF0 + ((r & 32'h3) << 2);
        default: tgt = r & 32'h0000_00FC;
      endcase
      step($urandom_range(9) < 7, rd, tgt);
    end
    repeat (3) step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the CPU pipeline: owns the fetch PC, drives the instruction memory address, and pairs each instruction returned one cycle later with its PC. It presents a valid/ready stream to decode and absorbs decode back-pressure with a one-entry hold buffer, so stalls cost no extra bubbles. It handles redirects from the branch/trap logic and carries misaligned-fetch exceptions forward.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, redirect target on misaligned fetch; used only when FETCH_TRAP_EN is defined.

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- o_pc  out  32  address to instruction memory; pc_q.
- i_insn  in  32  instruction memory data; registered, for the address driven one cycle earlier.
- i_imem_exception  in  1  misaligned flag; combinational on the current o_pc.
- i_redirect_valid  in  1  redirect request; single-cycle.
- i_redirect_pc  in  32  redirect target.
- o_valid  out  1  instruction valid to decode.
- i_ready  in  1  decode accepts; transfer when o_valid && i_ready.
- o_insn  out  32  instruction to decode.
- o_insn_pc  out  32  PC of o_insn.
- o_exception  out  1  o_insn came from a misaligned fetch.
- o_trap_pc  out  32  faulting PC of the last trap; present only with FETCH_TRAP_EN.

## Operation
- State: pc_q; in-flight tag r_valid/r_pc/r_exc, describing i_insn this cycle; hold buffer h_valid/h_insn/h_pc/h_exc.
- Output mux: h_valid ? hold buffer : {i_insn, r_pc, r_exc}. o_valid = (h_valid | r_valid) & ~i_redirect_valid.
- Two states: RUN (h_valid=0) and HOLD (h_valid=1).
- Events below are in priority order.
- Redirect: pc_q <= i_redirect_pc, r_valid <= 0, h_valid <= 0. This kills the current output and any held entry, in any state.
- RUN, o_valid && !i_ready (capture):
  - h_* <= current output; go to HOLD.
  - pc_q is held and r_valid <= 0, so the fetch in flight is discarded and re-issued.
- RUN, otherwise (advance): r_valid <= 1, r_pc <= pc_q, r_exc <= i_imem_exception, pc_q <= pc_q + 4.
- HOLD, !i_ready: everything held; o_pc stays at pc_q.
- HOLD, i_ready (release):
  - Hold entry transfers; h_valid <= 0; go to RUN.
  - Advance as in RUN, so the next instruction follows with no bubble.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- An exception slot drives o_insn = 32'h0000_0013 (NOP) in place of the memory data.

## Timing
- Reset values: pc_q = RESET_PC; r_valid = h_valid = 0; o_valid = 0; o_trap_pc = 0. o_pc = RESET_PC during reset.
- First instruction: o_valid rises in the 2nd cycle after reset release, carrying o_insn_pc = RESET_PC.
- Steady state: one instruction per cycle, PCs consecutive by 4.
- Redirect in cycle R:
  - o_valid = 0 in R and R+1.
  - o_pc = target in R+1.
  - Target instruction is valid in R+2.
- Stall of N cycles: the same instruction is held stable for N+1 cycles. The successor is valid the cycle after release.
- Redirect coincident with capture or release: the redirect wins and nothing transfers.
- Asynchronous reset mid-stall or mid-redirect: all state returns to reset values immediately.

## Configuration
- FETCH_TRAP_EN defined, on a slot advanced with i_imem_exception = 1:
  - That slot still reaches decode with o_exception = 1.
  - pc_q <= TRAP_VECTOR instead of pc_q + 4.
  - o_trap_pc <= faulting PC.
  - An external redirect in the same cycle wins.
- FETCH_TRAP_EN undefined:
  - The exception is only flagged on o_exception with a NOP instruction; fetch continues at pc_q + 4.
  - o_trap_pc port is absent.

## Test plan
- Reset release, i_ready=1, memory holding words 0x11,0x22,0x33 at 0,4,8 -> o_valid rises the 2nd cycle after release; (0,0x11),(4,0x22),(8,0x33) on consecutive cycles.
- i_ready low for 3 cycles while 0x22@4 is presented -> (4,0x22) stable for 4 cycles; (8,0x33) the cycle after i_ready rises; no duplicates, no skips.
- Redirect to 0x40 while stalled on 0x22@4 -> 0x22@4 never transfers; o_valid=0 for 2 cycles; then (0x40, mem[0x40]).
- Redirect to 0x42 -> (0x42, 0x13, o_exception=1).
  - With FETCH_TRAP_EN: next PC is 0x100 and o_trap_pc = 0x42.
  - Without: next PC is 0x46.
- Redirect to 0xFFFF_FFFC -> successor PC is 0x0000_0000.
- Assert i_rst_n low during a stall -> o_valid=0 immediately; the sequence restarts from RESET_PC after release.
